gpr_dump: RTL and testbench

Debug read-out engine for the general-purpose register file in the single-cycle processor. On a start pulse it walks the register file's combinational read port from FIRST_REG to NUM_REGS-1. It streams each register value, tagged with its index, to a downstream sink over a valid/ready handshake, then signals completion. It uses one read port only and never writes the register file.

---
 rtl/gpr_dump.sv | 118 +++++++++++
 tb/tb_gpr_dump.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump.sv
// Debug read-out engine: walks the GPR file read port from FIRST_REG to NUM_REGS-1
// and streams each value, tagged with its index, over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a start pulse
// LOAD  | rf_data at rf_addr captured into the output word
// SEND  | word offered to the sink until accepted
// DONE  | one-cycle completion pulse
module gpr_dump #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = 32,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   rf_addr_q,   rf_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [ADDR_W-1:0]   out_idx_q,   out_idx_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rf_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rf_addr_d = FIRST_IDX;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                out_data_d  = rf_data;
                out_idx_d   = rf_addr_q;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // The increment only happens below LAST_IDX, so rf_addr never wraps.
                    if (out_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        rf_addr_d = rf_addr_q + ADDR_W'(1);
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes the address and last word, drops valid and skips the done pulse.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            rf_addr_d   = rf_addr_q;
            out_data_d  = out_data_q;
            out_idx_d   = out_idx_q;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_gpr_dump.sv
// Bench for gpr_dump: directed dump scenarios with literal expectations, then a
// randomized phase compared every cycle against a word-stream model of the engine.
module tb_gpr_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int FR = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic [DW-1:0] rf [NR];

    assign rf_data = rf[rf_addr];

    gpr_dump #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .FIRST_REG(FR)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    // Small instance: dumps registers 1..3 of a 4-entry file whose value is 100+index.
    logic          s_start = 1'b0;
    logic          s_abort = 1'b0;
    logic          s_ready = 1'b1;
    logic [AW-1:0] s_rf_addr;
    logic [DW-1:0] s_rf_data;
    logic          s_valid;
    logic [DW-1:0] s_out_data;
    logic [AW-1:0] s_out_idx;
    logic          s_busy;
    logic          s_done;

    assign s_rf_data = DW'(100) + DW'(s_rf_addr);

    gpr_dump #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(4), .FIRST_REG(1)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .rf_addr(s_rf_addr), .rf_data(s_rf_data),
        .out_valid(s_valid), .out_ready(s_ready),
        .out_data(s_out_data), .out_idx(s_out_idx),
        .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Word-stream model: tracks the dump as "next word to fetch", "word on offer"
    // and "completion pending", advanced once per rising edge from the inputs.
    int            m_addr = 0;
    int            m_idx = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_busy = 0;
    bit            m_fetch = 0;
    bit            m_valid = 0;
    bit            m_done = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_addr = 0; m_idx = 0; m_data = '0;
            m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
        end else if (abort && m_busy) begin
            m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_fetch = 1; m_addr = FR;
            end
        end else if (m_fetch) begin
            m_idx = m_addr; m_data = rf[m_addr]; m_valid = 1; m_fetch = 0;
        end else if (out_ready) begin
            m_valid = 0;
            if (m_idx == NR - 1) m_done = 1;
            else begin
                m_addr++; m_fetch = 1;
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rf_addr",   64'(rf_addr),   64'(m_addr));
            check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
            check("cyc_out_data",  64'(out_data),  64'(m_data));
            check("cyc_out_idx",   64'(out_idx),   64'(m_idx));
            check("cyc_busy",      64'(busy),      64'(m_busy));
            check("cyc_done",      64'(done),      64'(m_done));
        end
    end

    int            w_idx[$];
    logic [DW-1:0] w_data[$];
    int            done_n;
    int            n_done;
    int            first_valid_n;
    int            last_busy_n;

    // Pulses start, then runs max_n+1 cycles; n counts edges after the one sampling start.
    // hold_idx: ready low 5 cycles on that word; abort_idx/rst_idx: abort or reset during
    // that word's SEND cycle; poke_idx: extra start pulses at that word and in the DONE cycle.
    task automatic run_dump(input int hold_idx, input int abort_idx, input int poke_idx,
                            input int rst_idx, input int max_n);
        int hold_left = 0;
        bit hold_arm = 0, abort_arm = 0, rst_arm = 0, poke_arm = 0, done_poke_arm = 0;
        bit did_hold = 0, did_abort = 0, did_rst = 0, did_poke = 0;
        int abort_chk_n = -1, rst_chk_n = -1;
        w_idx.delete(); w_data.delete();
        done_n = -1; n_done = 0; first_valid_n = -1; last_busy_n = -1;
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1; abort = 1'b0; rst = 1'b1;
        for (int n = 0; n <= max_n; n++) begin
            @(posedge clk); #1;
            start = poke_arm || done_poke_arm;
            poke_arm = 0; done_poke_arm = 0;
            abort = abort_arm; abort_arm = 0;
            rst = !rst_arm; rst_arm = 0;
            if (hold_arm) begin
                hold_left = 5; hold_arm = 0;
            end
            out_ready = (hold_left == 0);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_n < 0) done_n = n;
            end
            if (busy) last_busy_n = n;
            if (out_valid && first_valid_n < 0) first_valid_n = n;
            if (out_valid && out_ready) begin
                w_idx.push_back(int'(out_idx));
                w_data.push_back(out_data);
            end
            if (hold_left > 0) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_idx",   64'(out_idx),   64'(hold_idx));
                check("hold_data",  64'(out_data),  64'(3 * hold_idx));
                hold_left--;
            end
            if (n == abort_chk_n) begin
                check("abort_valid", 64'(out_valid), 64'(0));
                check("abort_busy",  64'(busy),      64'(0));
                check("abort_done",  64'(done),      64'(0));
            end
            if (n == rst_chk_n) begin
                check("rst_rf_addr",   64'(rf_addr),   64'(0));
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_out_data",  64'(out_data),  64'(0));
                check("rst_out_idx",   64'(out_idx),   64'(0));
                check("rst_busy",      64'(busy),      64'(0));
                check("rst_done",      64'(done),      64'(0));
            end
            if (busy && !out_valid && !done) begin
                if (!did_hold && int'(rf_addr) == hold_idx) begin
                    hold_arm = 1; did_hold = 1;
                end
                if (!did_abort && int'(rf_addr) == abort_idx) begin
                    abort_arm = 1; did_abort = 1; abort_chk_n = n + 2;
                end
                if (!did_rst && int'(rf_addr) == rst_idx) begin
                    rst_arm = 1; did_rst = 1; rst_chk_n = n + 2;
                end
            end
            if (!did_poke && out_valid && int'(out_idx) == poke_idx) begin
                poke_arm = 1; did_poke = 1;
            end
            if (poke_idx >= 0 && out_valid && out_ready && int'(out_idx) == NR - 1)
                done_poke_arm = 1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b1; out_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int count);
        check({tag, "_count"}, 64'(w_idx.size()), 64'(count));
        for (int k = 0; k < w_idx.size() && k < count; k++) begin
            check({tag, "_idx"},  64'(w_idx[k]),  64'(k));
            check({tag, "_data"}, 64'(w_data[k]), 64'(3 * k));
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) rf[i] = DW'(3 * i);
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        check("reset_rf_addr",   64'(rf_addr),   64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data",  64'(out_data),  64'(0));
        check("reset_busy",      64'(busy),      64'(0));
        check("reset_done",      64'(done),      64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Full dump, sink always ready: done seen after the 64th edge, busy falls with it.
        run_dump(-1, -1, -1, -1, 70);
        check_stream("full", 32);
        check("full_done_cycle", 64'(done_n), 64'(64));
        check("full_done_count", 64'(n_done), 64'(1));
        check("full_first_valid", 64'(first_valid_n), 64'(1));
        check("full_last_busy", 64'(last_busy_n), 64'(64));

        // Backpressure on word 7 for 5 cycles stretches the dump by 5.
        run_dump(7, -1, -1, -1, 80);
        check_stream("hold", 32);
        check("hold_done_cycle", 64'(done_n), 64'(69));
        check("hold_done_count", 64'(n_done), 64'(1));

        // Abort while word 10 is on offer (handshake in the same cycle): 11 words, no done.
        run_dump(-1, 10, -1, -1, 40);
        check_stream("abort", 11);
        check("abort_done_count", 64'(n_done), 64'(0));
        run_dump(-1, -1, -1, -1, 70);
        check_stream("after_abort", 32);
        check("after_abort_done", 64'(n_done), 64'(1));

        // Start re-pulsed mid-dump and in the DONE cycle is ignored.
        run_dump(-1, -1, 4, -1, 90);
        check_stream("poke", 32);
        check("poke_done_count", 64'(n_done), 64'(1));
        check("poke_last_busy", 64'(last_busy_n), 64'(64));

        // Reset at word 15, then stay idle with start low.
        run_dump(-1, -1, -1, 15, 40);
        check("rst_done_count", 64'(n_done), 64'(0));
        check("rst_idle_busy", 64'(busy), 64'(0));

        // Reduced instance: registers 1..3 only.
        begin
            int s_words = 0;
            int s_done_n = -1;
            int s_max_addr = 0;
            @(posedge clk); #1 s_start = 1'b1;
            @(posedge clk); #1 s_start = 1'b0;
            for (int n = 0; n <= 12; n++) begin
                @(negedge clk);
                if (int'(s_rf_addr) > s_max_addr) s_max_addr = int'(s_rf_addr);
                if (s_done && s_done_n < 0) s_done_n = n;
                if (s_valid && s_ready) begin
                    check("small_idx",  64'(s_out_idx),  64'(1 + s_words));
                    check("small_data", 64'(s_out_data), 64'(101 + s_words));
                    s_words++;
                end
            end
            check("small_words", 64'(s_words), 64'(3));
            check("small_done_cycle", 64'(s_done_n), 64'(6));
            check("small_max_addr", 64'(s_max_addr), 64'(3));
            check("small_idle", 64'(s_busy), 64'(0));
        end

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 6);
            start     = ($urandom_range(0, 9) < 2);
            abort     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0) rf[$urandom_range(0, NR - 1)] = DW'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
